otg_hpi_bus_master: RTL and testbench
=====================================

// Module: otg_hpi_bus_master
// PURPOSE
//  Hardware initiator for the CY7C67200 EZ-OTG Host Port Interface (HPI). It accepts one
//  16-bit register read or write per command and drives the HPI pins with programmable
//  setup/strobe/hold/recovery timing. It replaces software bit-banging of the HPI through
//  the data, address, cs, rd and wr PIOs. The data tristate buffer sits in the top level.
// PARAMETERS
//  SETUP_CYC     1  cycles cs_n low + addr/data valid before strobe asserts (1..15)
//  STROBE_CYC    4  cycles rd_n/wr_n held low (1..15)
//  HOLD_CYC      1  cycles after strobe deasserts with cs_n, addr and data still held (1..15)
//  RECOVERY_CYC  2  cycles cs_n high between transactions (1..15)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   command accepted when cmd_valid && cmd_ready
//  cmd_write     in   1   1 = HPI write, 0 = HPI read
//  cmd_addr      in   2   HPI register: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//  cmd_wdata     in   16  write data
//  rsp_valid     out  1   one-cycle pulse when a transaction completes its strobe
//  rsp_write     out  1   echoes cmd_write of the completing transaction
//  rsp_rdata     out  16  read data, valid with rsp_valid (0 for writes)
//  otg_addr      out  2   HPI address pins
//  otg_cs_n      out  1   HPI chip select, active low
//  otg_rd_n      out  1   HPI read strobe, active low
//  otg_wr_n      out  1   HPI write strobe, active low
//  otg_data_out  out  16  data driven to the tristate buffer
//  otg_data_oe   out  1   tristate enable (1 = FPGA drives the bus)
//  otg_data_in   in   16  data sampled from the bus
// BEHAVIOUR
//  - All outputs are registered. Reset values: cs_n=rd_n=wr_n=1, oe=0, addr=0, data_out=0,
//    rsp_valid=0, rsp_write=0, rsp_rdata=0, state=IDLE, so cmd_ready=1 after the reset edge.
//  - cmd_ready = (state==IDLE), decoded from the state register. Only one command is in flight.
//  - FSM: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. A 4-bit down-counter is
//    loaded with N-1 on entry to each state; the state advances when the count reaches 0.
//  - Handshake edge: latch addr, wdata and write; go to SETUP. cs_n=0 and addr are driven.
//    For writes, oe=1 and data_out=wdata.
//  - STROBE: wr_n=0 (write) or rd_n=0 (read). cs_n, addr and data stay stable.
//  - Read capture: otg_data_in is registered into rsp_rdata on the clock edge that ends the
//    last STROBE cycle.
//  - HOLD: strobe=1, cs_n=0, addr/data/oe unchanged. rsp_valid=1 during the first HOLD cycle only.
//  - RECOVER: cs_n=1, oe=0 (bus released), addr held.
//  - Per-command occupancy is SETUP+STROBE+HOLD+RECOVERY cycles, followed by 1 IDLE cycle.
//    With the defaults, back-to-back commands start every 9 cycles.
//  - Strobe and cs_n never change on the same edge. oe falls only with or after cs_n rising.
//  - Command inputs are ignored outside IDLE. Latched values are immune to input changes.
//  - Reset mid-transaction: on the next edge all pins return to reset values (strobe aborted,
//    bus released). No rsp_valid is issued for the aborted command.
//  - rsp_rdata keeps its last value until the next read completes. On a write it is
//    cleared to 0.
// STRUCTURE
//  - Shared package otg_hpi_pkg: HPI register constants (HPI_DATA=2'd0, HPI_MAILBOX=2'd1,
//    HPI_ADDRESS=2'd2, HPI_STATUS=2'd3) and the state encoding (IDLE, SETUP, STROBE, HOLD,
//    RECOVER). A future HPI responder model shares both.
//  - Single module with no sub-modules. The FSM and the phase counter are one always block.
//    The output register block is separate.
// TESTING (defaults; handshake edge = cycle 0)
//  1. Write addr=2, wdata=0x1234 -> cs_n=0 cycles 1-6, wr_n=0 cycles 2-5, oe=1 and
//     data_out=0x1234 cycles 1-6, rd_n=1 throughout, rsp_valid at cycle 6, cmd_ready=1 at cycle 9.
//  2. Read addr=0 with otg_data_in=0xBEEF during cycles 2-5 and 0x0000 afterwards ->
//     rsp_rdata=0xBEEF, rsp_valid=1, rsp_write=0 at cycle 6. oe stays 0.
//  3. Back-to-back: cmd_valid held high for write 0x0100 to ADDRESS then read DATA ->
//     second accept at cycle 9, its cs_n falls at cycle 10. cs_n is high for cycles 7-9.
//  4. reset=1 sampled at the edge ending cycle 3 (mid-STROBE) -> cycle 4 shows cs_n=wr_n=1,
//    oe=0 and cmd_ready=1. No rsp_valid follows.
//  5. Parameters SETUP=2, STROBE=1, HOLD=3, RECOVERY=1; read -> rd_n=0 only at cycle 3,
//    rsp_valid at cycle 4, cs_n low cycles 1-6, next accept at cycle 8.
//  6. Change cmd_wdata/cmd_addr every cycle during a write -> pins keep the values latched at
//    the handshake. Assert the ordering rules (strobe vs cs_n, oe vs cs_n) hold across a
//    1000-command random run.

Source files
------------

// File: rtl/otg_hpi_pkg.sv
// Shared definitions for the CY7C67200 Host Port Interface: register selects and bus-cycle phases.
// The initiator and any future responder model both import this.
package otg_hpi_pkg;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } hpi_state_t;

    // Phase counters count down to zero, so a phase lasting N cycles starts at N-1.
    function automatic logic [3:0] phase_load(input int unsigned cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/otg_hpi_bus_master.sv
// HPI bus initiator: runs one 16-bit register read or write per command with programmable
// setup/strobe/hold/recovery timing. All pin outputs come straight from flops.
module otg_hpi_bus_master
    import otg_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    hpi_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lat_write;
    logic       start;
    logic       txn_write;
    logic       in_txn_d;
    logic       strobe_done;

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    cnt_d   = phase_load(SETUP_CYC);
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = phase_load(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = phase_load(HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = RECOVER;
                    cnt_d   = phase_load(RECOVERY_CYC);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pins are registered from the next state so they switch on the same edge as the phase.
    assign start       = (state_q == IDLE) && cmd_valid;
    assign txn_write   = start ? cmd_write : lat_write;
    assign in_txn_d    = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    assign strobe_done = (state_q == STROBE) && (state_d == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_write    <= 1'b0;
            otg_addr     <= 2'd0;
            otg_data_out <= 16'd0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= 16'd0;
        end else begin
            if (start) begin
                lat_write <= cmd_write;
                otg_addr  <= cmd_addr;
                if (cmd_write) begin
                    otg_data_out <= cmd_wdata;
                end
            end
            otg_cs_n    <= !in_txn_d;
            otg_data_oe <= in_txn_d && txn_write;
            otg_wr_n    <= !((state_d == STROBE) && txn_write);
            otg_rd_n    <= !((state_d == STROBE) && !txn_write);
            rsp_valid   <= strobe_done;
            if (strobe_done) begin
                rsp_write <= lat_write;
                rsp_rdata <= lat_write ? 16'd0 : otg_data_in;
            end
        end
    end

endmodule

// File: tb/tb_otg_hpi_bus_master.sv
// Directed and random checks of the HPI initiator pin timing, read capture, reset abort and ordering.
module tb_otg_hpi_bus_master;
    import otg_hpi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_write;
    logic [15:0] rsp_rdata;
    logic [1:0]  otg_addr;
    logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe;
    logic [15:0] otg_data_out, otg_data_in;

    logic        v2, ready2, write2;
    logic [1:0]  addr2;
    logic [15:0] wdata2;
    logic        rv2, rw2;
    logic [15:0] rdata2;
    logic [1:0]  oaddr2;
    logic        cs2, rd2, wr2, oe2;
    logic [15:0] dout2, din2;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    otg_hpi_bus_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
        .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
    );

    otg_hpi_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVERY_CYC(1)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(v2), .cmd_ready(ready2), .cmd_write(write2),
        .cmd_addr(addr2), .cmd_wdata(wdata2),
        .rsp_valid(rv2), .rsp_write(rw2), .rsp_rdata(rdata2),
        .otg_addr(oaddr2), .otg_cs_n(cs2), .otg_rd_n(rd2), .otg_wr_n(wr2),
        .otg_data_out(dout2), .otg_data_oe(oe2), .otg_data_in(din2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ordering monitor: strobe and cs_n never switch together; oe never drops while cs_n is low.
    logic rst_seen, p_cs, p_st, p_oe;
    always @(posedge clk) begin
        rst_seen = reset;
        #2;
        if (mon_en && !rst_seen) begin
            total++;
            assert (!((otg_cs_n !== p_cs) && ((otg_rd_n & otg_wr_n) !== p_st))) else begin
                bad++;
                $error("[TB] FAIL order_strobe_cs observed cs=%b st=%b prev cs=%b st=%b",
                       otg_cs_n, otg_rd_n & otg_wr_n, p_cs, p_st);
            end
            total++;
            assert (!(p_oe && !otg_data_oe && !otg_cs_n)) else begin
                bad++;
                $error("[TB] FAIL order_oe_cs observed oe fell with cs_n=%b required cs_n=1", otg_cs_n);
            end
        end
        p_cs = otg_cs_n;
        p_st = otg_rd_n & otg_wr_n;
        p_oe = otg_data_oe;
    end

    initial begin
        bit          hs, pend, pw;
        logic [1:0]  pa;
        logic [15:0] pd, pin;
        int          acc, nrsp;

        reset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; otg_data_in = 0;
        v2 = 0; write2 = 0; addr2 = 0; wdata2 = 0; din2 = 0;
        step();
        step();
        chk("rst_cs_n", otg_cs_n, 1);
        chk("rst_rd_n", otg_rd_n, 1);
        chk("rst_wr_n", otg_wr_n, 1);
        chk("rst_oe", otg_data_oe, 0);
        chk("rst_addr", otg_addr, 0);
        chk("rst_dout", otg_data_out, 0);
        chk("rst_rsp", {rsp_valid, rsp_write, rsp_rdata}, 0);
        chk("rst_ready", cmd_ready, 1);
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Write 0x1234 to ADDRESS while the command inputs keep changing underneath it.
        cmd_valid = 1; cmd_write = 1; cmd_addr = HPI_ADDRESS; cmd_wdata = 16'h1234;
        for (int c = 1; c <= 9; c++) begin
            step();
            cmd_valid = 0;
            cmd_addr  = 2'(c);
            cmd_wdata = 16'($urandom);
            chk($sformatf("w_cs_c%0d", c), otg_cs_n, !(c <= 6));
            chk($sformatf("w_wr_c%0d", c), otg_wr_n, !(c >= 2 && c <= 5));
            chk($sformatf("w_rd_c%0d", c), otg_rd_n, 1);
            chk($sformatf("w_oe_c%0d", c), otg_data_oe, (c <= 6));
            if (c <= 6) begin
                chk($sformatf("w_dout_c%0d", c), otg_data_out, 16'h1234);
                chk($sformatf("w_addr_c%0d", c), otg_addr, 2);
            end
            chk($sformatf("w_rv_c%0d", c), rsp_valid, (c == 6));
            chk($sformatf("w_ready_c%0d", c), cmd_ready, (c == 9));
        end

        // Read DATA with 0xBEEF on the bus only while the strobe is low.
        cmd_valid = 1; cmd_write = 0; cmd_addr = HPI_DATA;
        for (int c = 1; c <= 9; c++) begin
            step();
            cmd_valid = 0;
            otg_data_in = (c >= 2 && c <= 5) ? 16'hBEEF : 16'h0000;
            chk($sformatf("r_rd_c%0d", c), otg_rd_n, !(c >= 2 && c <= 5));
            chk($sformatf("r_wr_c%0d", c), otg_wr_n, 1);
            chk($sformatf("r_oe_c%0d", c), otg_data_oe, 0);
            chk($sformatf("r_cs_c%0d", c), otg_cs_n, !(c <= 6));
            chk($sformatf("r_rv_c%0d", c), rsp_valid, (c == 6));
            if (c == 6) begin
                chk("r_rdata", rsp_rdata, 16'hBEEF);
                chk("r_rwrite", rsp_write, 0);
            end
        end
        chk("r_rdata_kept", rsp_rdata, 16'hBEEF);

        // Back-to-back: write 0x0100 to ADDRESS then read DATA with valid held high.
        otg_data_in = 16'h5A5A;
        cmd_valid = 1; cmd_write = 1; cmd_addr = HPI_ADDRESS; cmd_wdata = 16'h0100;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c == 1) begin
                cmd_write = 0; cmd_addr = HPI_DATA;
            end
            if (c == 10) cmd_valid = 0;
            chk($sformatf("b_cs_c%0d", c), otg_cs_n, !((c <= 6) || (c >= 10 && c <= 15)));
            chk($sformatf("b_ready_c%0d", c), cmd_ready, (c == 9 || c == 18));
            chk($sformatf("b_rv_c%0d", c), rsp_valid, (c == 6 || c == 15));
            chk($sformatf("b_rd_c%0d", c), otg_rd_n, !(c >= 11 && c <= 14));
            if (c == 6) begin
                chk("b_w_rwrite", rsp_write, 1);
                chk("b_w_rdata", rsp_rdata, 0);
            end
            if (c == 10) chk("b_r_addr", otg_addr, HPI_DATA);
            if (c == 15) begin
                chk("b_r_rwrite", rsp_write, 0);
                chk("b_r_rdata", rsp_rdata, 16'h5A5A);
            end
        end

        // Reset during the strobe aborts the write with no response.
        cmd_valid = 1; cmd_write = 1; cmd_addr = HPI_MAILBOX; cmd_wdata = 16'hABCD;
        step();
        cmd_valid = 0;
        step();
        step();
        chk("a_wr_c3", otg_wr_n, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("a_cs", otg_cs_n, 1);
        chk("a_wr", otg_wr_n, 1);
        chk("a_rd", otg_rd_n, 1);
        chk("a_oe", otg_data_oe, 0);
        chk("a_ready", cmd_ready, 1);
        for (int c = 4; c <= 12; c++) begin
            chk($sformatf("a_norsp_c%0d", c), rsp_valid, 0);
            step();
        end

        // Alternate timing instance: SETUP=2 STROBE=1 HOLD=3 RECOVERY=1 read of STATUS.
        v2 = 1; write2 = 0; addr2 = HPI_STATUS; din2 = 16'hA5A5;
        for (int c = 1; c <= 8; c++) begin
            step();
            v2 = 0;
            chk($sformatf("p_rd_c%0d", c), rd2, !(c == 3));
            chk($sformatf("p_rv_c%0d", c), rv2, (c == 4));
            chk($sformatf("p_cs_c%0d", c), cs2, !(c <= 6));
            chk($sformatf("p_ready_c%0d", c), ready2, (c == 8));
            if (c == 4) chk("p_rdata", rdata2, 16'hA5A5);
        end

        // Random command stream checked against the values latched at each handshake.
        acc = 0; nrsp = 0; pend = 0; pw = 0; pa = 0; pd = 0; pin = 0;
        for (int cyc = 0; cyc < 30000 && nrsp < 1000; cyc++) begin
            cmd_valid = ($urandom_range(0, 1) == 1) && (acc < 1000);
            cmd_write = 1'($urandom);
            cmd_addr  = 2'($urandom);
            cmd_wdata = 16'($urandom);
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) begin
                pend = 1; pw = cmd_write; pa = cmd_addr; pd = cmd_wdata;
                acc++;
                otg_data_in = 16'($urandom);
                pin = otg_data_in;
            end
            if (!otg_cs_n) begin
                chk("x_addr", otg_addr, pa);
                chk("x_oe", otg_data_oe, pw);
                if (pw) chk("x_dout", otg_data_out, pd);
            end
            if (rsp_valid) begin
                chk("x_pend", pend, 1);
                chk("x_rwrite", rsp_write, pw);
                chk("x_rdata", rsp_rdata, pw ? 16'h0 : pin);
                nrsp++;
                pend = 0;
            end
        end
        cmd_valid = 0;
        chk("x_count", nrsp, 1000);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
